johnson_seq_ctrl: RTL

Controller that sequences a switch-tail (Johnson) ring counter of run-time-selectable length, from 1 to MAXW stages.
- Accepts a length configuration, then starts the counter and stops it cleanly at a period boundary.
- Reports phase and end-of-period ticks.
- Detects illegal (lock-up) counter patterns and recovers from them.
- Sits between lab control logic (buttons/FSM) and the waveform outputs (x/y/z style taps) derived from q.

---
 rtl/johnson_seq_ctrl_if.sv | 26 ++
 rtl/johnson_seq_ctrl.sv | 80 ++++++++
 2 files changed

// File: rtl/johnson_seq_ctrl_if.sv
// johnson_seq_ctrl_if: control/status bundle for the Johnson sequencer (JSEQ_PRELOAD_EN adds preload).
interface johnson_seq_ctrl_if #(parameter int MAXW = 8);
    logic            cfg_valid;
    logic [3:0]      cfg_len;
    logic            cfg_ready;
    logic            start;
    logic            stop;
    logic [MAXW-1:0] q;
    logic [4:0]      phase;
    logic            tick;
    logic            busy;
    logic            err;
`ifdef JSEQ_PRELOAD_EN
    logic            pre_valid;
    logic [MAXW-1:0] pre_val;
    modport master (output cfg_valid, cfg_len, start, stop, pre_valid, pre_val,
                    input cfg_ready, q, phase, tick, busy, err);
    modport slave  (input cfg_valid, cfg_len, start, stop, pre_valid, pre_val,
                    output cfg_ready, q, phase, tick, busy, err);
`else
    modport master (output cfg_valid, cfg_len, start, stop,
                    input cfg_ready, q, phase, tick, busy, err);
    modport slave  (input cfg_valid, cfg_len, start, stop,
                    output cfg_ready, q, phase, tick, busy, err);
`endif
endinterface

// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl: variable-length Johnson counter sequencer with lock-up recovery (JSEQ_PRELOAD_EN adds preload).
module johnson_seq_ctrl #(parameter int MAXW = 8) (
    input logic              clk,
    input logic              rst,
    johnson_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
    state_t          state, state_n;
    logic [3:0]      len, len_n;
    logic [MAXW-1:0] q_r, mask, mask_n, qc, qs, start_q;
    logic [4:0]      ph_r, ph_end;
    logic            err_r, active, last, illegal, cfg_acc, cfg_ok, go, top;
    assign active  = state != IDLE;
    assign cfg_acc = state == IDLE && bus.cfg_valid;
    assign cfg_ok  = bus.cfg_len != 4'd0 && bus.cfg_len <= 4'(MAXW);
    assign go      = state == IDLE && bus.start && !bus.stop;
    assign len_n   = (cfg_acc && cfg_ok) ? bus.cfg_len : len;
    assign mask    = MAXW'((32'd1 << len) - 32'd1);
    assign mask_n  = MAXW'((32'd1 << len_n) - 32'd1);
    assign qc      = ~q_r & mask;
    // a legal pattern is a run of ones from bit 0, or the len-bit complement of one
    assign illegal = ((q_r & (q_r + MAXW'(1))) != '0) && ((qc & (qc + MAXW'(1))) != '0);
    assign top     = |(q_r & mask & ~(mask >> 1));
    assign qs      = {q_r[MAXW-2:0], ~top} & mask;
    assign ph_end  = {len, 1'b0} - 5'd1;
    assign last    = ph_r == ph_end;
`ifdef JSEQ_PRELOAD_EN
    logic [MAXW-1:0] pre_q;
    assign start_q = (bus.pre_valid ? bus.pre_val : pre_q) & mask_n;
    // one-shot preload register, consumed by the next start
    always_ff @(posedge clk)
        if (rst || go) pre_q <= '0;
        else if (state == IDLE && bus.pre_valid) pre_q <= bus.pre_val & mask_n;
`else
    assign start_q = '0;
`endif
    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    // next state; lock-up recovery holds the state, stop only exits on the period's last phase
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     state_n = go ? RUN : IDLE;
            RUN:      state_n = (illegal || !bus.stop) ? RUN : last ? IDLE : STOPPING;
            STOPPING: state_n = (!illegal && last) ? IDLE : STOPPING;
            default:  state_n = IDLE;
        endcase
    end
    // counter, phase, length and error pulse
    always_ff @(posedge clk)
        if (rst) begin
            q_r   <= '0;
            ph_r  <= '0;
            len   <= 4'(MAXW);
            err_r <= 1'b0;
        end else begin
            err_r <= (cfg_acc && !cfg_ok) || (active && illegal);
            len   <= len_n;
            if (!active) begin
                q_r  <= go ? start_q : '0;
                ph_r <= '0;
            end else if (illegal || state_n == IDLE) begin
                q_r  <= '0;
                ph_r <= '0;
            end else begin
                q_r  <= qs;
                ph_r <= last ? 5'd0 : ph_r + 5'd1;
            end
        end
    // status outputs
    always_comb begin
        bus.q         = q_r;
        bus.phase     = ph_r;
        bus.err       = err_r;
        bus.busy      = active;
        bus.cfg_ready = !active;
        bus.tick      = active && last;
    end
endmodule
